nis_cpu_uart_cpu_cpu_debug_mem_ctrl: RTL and testbench
======================================================

// Module: nis_cpu_uart_cpu_cpu_debug_mem_ctrl
// PURPOSE
//  Consumes the sysclk-domain debug command stream (jdo + ocimem strobes) from the debug slave.
//  Turns it into word reads/writes on a waitrequest-style memory master port.
//  Returns read data on MonDReg for the debug slave's TCK-side capture.
//  Auto-increments the word address so the host can stream memory contents.
// PARAMETERS
//  AW       10   word-address width of mem_addr and the internal address register
//  DW       32   data width; fixed at 32 to match MonDReg and jdo[34:3]
// PORTS
//  clk                     in   1   system clock; all logic rises on clk
//  reset_n                 in   1   synchronous reset, active-low
//  jdo                     in   38  debug command/data word, stable while any strobe is high
//  take_action_ocimem_a    in   1   1-cycle strobe: load address (optional prime read / flag clear)
//  take_no_action_ocimem_a in   1   1-cycle strobe: read at current address, then increment
//  take_action_ocimem_b    in   1   1-cycle strobe: write jdo[34:3] at current address, then increment
//  mem_addr                out  AW  word address to memory
//  mem_rd                  out  1   read request, held until accepted
//  mem_wr                  out  1   write request, held until accepted
//  mem_wdata               out  32  write data
//  mem_waitrequest         in   1   1 = request not accepted this cycle
//  mem_rdata               in   32  read data
//  mem_rvalid              in   1   read data valid (1 cycle per accepted read)
//  MonDReg                 out  32  last read data
//  mon_busy                out  1   1 whenever FSM is not IDLE
//  mon_drop                out  1   sticky: a strobe arrived while busy
//  mon_err                 out  1   sticky: write-verify mismatch (only with macro)
// BEHAVIOUR
//  Reset (reset_n=0 at a clk edge):
//   - state=IDLE; addr=0; MonDReg=0.
//   - mem_rd=mem_wr=0; mem_wdata=0; mon_busy/mon_drop/mon_err=0.
//   - Takes effect mid-transaction: requests drop on that edge; late mem_rvalid is ignored.
//  FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, VFY_REQ, VFY_WAIT.
//  IDLE strobe priority when several are high: action_a > action_b > no_action_a.
//   - action_a: addr<=jdo[AW+2:3]; if jdo[36]=1, clear mon_drop and mon_err.
//     If jdo[35]=1 -> RD_REQ (prime read, no increment afterwards); else stay IDLE.
//   - no_action_a: -> RD_REQ (read with increment).
//   - action_b: mem_wdata<=jdo[34:3] -> WR_REQ.
//  RD_REQ: mem_rd=1, mem_addr=addr. Go to RD_WAIT on the first cycle with mem_waitrequest=0.
//   - If mem_rvalid is high in that same cycle, capture the data and go straight to IDLE.
//  RD_WAIT: on mem_rvalid: MonDReg<=mem_rdata; addr<=addr+1 (increment reads only); -> IDLE.
//  WR_REQ: mem_wr=1 until mem_waitrequest=0. Then addr<=addr+1 and -> IDLE (or VFY_REQ with macro).
//  Minimum latency, strobe to back in IDLE (zero wait states):
//   - read, rvalid one cycle after accept: 3 clks.
//   - write: 2 clks.
//  Address increments modulo 2^AW: 2^AW-1 wraps to 0 with no flag.
//  Any strobe while state!=IDLE is dropped and sets mon_drop. State and addr are unchanged.
//  mem_rd and mem_wr are never high together; mem_addr/mem_wdata are stable while a request is held.
//  MonDReg changes only on read completion or reset.
// CONFIGURATION
//  Macro DEBUG_MEM_WR_VERIFY_EN defined:
//   - After a write is accepted, VFY_REQ re-reads the written address (pre-increment value).
//   - VFY_WAIT compares on mem_rvalid; mismatch sets mon_err.
//   - MonDReg takes the read-back value; addr increments only when VFY_WAIT completes.
//  Macro not defined:
//   - VFY states do not exist; mon_err is tied to 0; a write returns to IDLE after accept.
// TESTING
//  1 Reset: reset_n=0 for 2 clks during RD_WAIT -> IDLE, mem_rd=0, MonDReg=0, late rvalid ignored.
//  2 Stream read: action_a jdo addr=0x3FE, then 3x no_action_a with rdata A,B,C
//    -> MonDReg=A,B,C in turn; addr 0x3FE,0x3FF,0x000, then 0x001 (wrap).
//  3 Write with waitrequest=1 for 4 clks, jdo[34:3]=0xDEADBEEF, addr=5
//    -> mem_wr held 5 clks, addr/wdata stable, addr=6 afterwards.
//  4 Simultaneous action_a+action_b in IDLE -> address load only; no mem_wr.
//    no_action_a during RD_WAIT -> mon_drop=1; cleared by action_a with jdo[36]=1.
//  5 Verify macro: write 0x12345678 to addr 7, read-back 0x12345679
//    -> mon_err=1, MonDReg=0x12345679, addr=8. Without macro: mon_err stays 0.

Source files
------------

// File: rtl/nis_cpu_uart_cpu_cpu_debug_mem_ctrl_if.sv
// ----------------------------------------------------------------------------
// nis_cpu_uart_cpu_cpu_debug_mem_ctrl_if
//
// Purpose:
//   Word-wide, waitrequest-style memory bus between the debug memory
//   controller (master) and the memory it accesses (slave).
//
// Signals:
//   mem_addr        master -> slave  AW  word address
//   mem_rd          master -> slave  1   read request, held until accepted
//   mem_wr          master -> slave  1   write request, held until accepted
//   mem_wdata       master -> slave  32  write data
//   mem_waitrequest slave  -> master 1   1 = request not accepted this cycle
//   mem_rdata       slave  -> master 32  read data
//   mem_rvalid      slave  -> master 1   read data valid, one cycle per read
// ----------------------------------------------------------------------------
interface nis_cpu_uart_cpu_cpu_debug_mem_ctrl_if #(
    parameter int AW = 10
) ();
    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [31:0]   mem_wdata;
    logic          mem_waitrequest;
    logic [31:0]   mem_rdata;
    logic          mem_rvalid;

    modport master (
        output mem_addr,
        output mem_rd,
        output mem_wr,
        output mem_wdata,
        input  mem_waitrequest,
        input  mem_rdata,
        input  mem_rvalid
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        input  mem_wr,
        input  mem_wdata,
        output mem_waitrequest,
        output mem_rdata,
        output mem_rvalid
    );
endinterface

// File: rtl/nis_cpu_uart_cpu_cpu_debug_mem_ctrl.sv
// ----------------------------------------------------------------------------
// nis_cpu_uart_cpu_cpu_debug_mem_ctrl
//
// Purpose:
//   Turns the sysclk-domain debug command stream (jdo plus ocimem strobes)
//   into single-word reads and writes on a waitrequest-style memory master
//   port. Read data is returned on MonDReg for the debug slave's TCK-side
//   capture. The word address auto-increments so the host can stream memory.
//
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   jdo[37:0]                     command/data word, stable while a strobe is high
//                                   [36] clear sticky flags, [35] prime read,
//                                   [34:3] write data / load address
//   take_action_ocimem_a          load address (optional prime read / flag clear)
//   take_no_action_ocimem_a       read at current address, then increment
//   take_action_ocimem_b          write jdo[34:3] at current address, then increment
//   mem (master modport)          memory bus
//   MonDReg[DW-1:0]               last read data
//   mon_busy                      controller is not idle
//   mon_drop                      sticky: a strobe arrived while busy
//   mon_err                       sticky: write-verify mismatch
//
// Configuration:
//   DEBUG_MEM_WR_VERIFY_EN  when defined, every accepted write is followed by
//                           a read-back of the same address; a mismatch sets
//                           mon_err. When undefined mon_err is tied low.
// ----------------------------------------------------------------------------
module nis_cpu_uart_cpu_cpu_debug_mem_ctrl #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [37:0]                          jdo,
    input  logic                                 take_action_ocimem_a,
    input  logic                                 take_no_action_ocimem_a,
    input  logic                                 take_action_ocimem_b,
    nis_cpu_uart_cpu_cpu_debug_mem_ctrl_if.master mem,
    output logic [DW-1:0]                        MonDReg,
    output logic                                 mon_busy,
    output logic                                 mon_drop,
    output logic                                 mon_err
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_REQ   = 3'd1;
    localparam logic [2:0] ST_RD_WAIT  = 3'd2;
    localparam logic [2:0] ST_WR_REQ   = 3'd3;
`ifdef DEBUG_MEM_WR_VERIFY_EN
    localparam logic [2:0] ST_VFY_REQ  = 3'd4;
    localparam logic [2:0] ST_VFY_WAIT = 3'd5;
`endif

    logic [2:0]    state_q,     state_d;
    logic [AW-1:0] addr_q,      addr_d;
    logic [DW-1:0] mon_dreg_q,  mon_dreg_d;
    logic [DW-1:0] wdata_q,     wdata_d;
    logic          drop_q,      drop_d;
    logic          incr_q,      incr_d;
`ifdef DEBUG_MEM_WR_VERIFY_EN
    logic          err_q,       err_d;
`endif

    logic any_strobe;
    logic in_req;
    logic in_wait;
    logic is_vfy;
    logic rd_done;

    // jdo[2:0] carry debug-slave framing and jdo[37] is not a memory command bit
    logic unused_jdo_bits;
    assign unused_jdo_bits = ^{jdo[37], jdo[2:0]};

    assign any_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

`ifdef DEBUG_MEM_WR_VERIFY_EN
    assign in_req  = (state_q == ST_RD_REQ)  || (state_q == ST_VFY_REQ);
    assign in_wait = (state_q == ST_RD_WAIT) || (state_q == ST_VFY_WAIT);
    assign is_vfy  = (state_q == ST_VFY_REQ) || (state_q == ST_VFY_WAIT);
`else
    assign in_req  = (state_q == ST_RD_REQ);
    assign in_wait = (state_q == ST_RD_WAIT);
    assign is_vfy  = 1'b0;
`endif

    // A read (normal or verify) completes either on the accept cycle, when
    // the slave returns data with zero latency, or later in the wait state.
    assign rd_done = (in_req && !mem.mem_waitrequest && mem.mem_rvalid) ||
                     (in_wait && mem.mem_rvalid);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mon_dreg_d = mon_dreg_q;
        wdata_d    = wdata_q;
        drop_d     = drop_q;
        incr_d     = incr_q;
`ifdef DEBUG_MEM_WR_VERIFY_EN
        err_d      = err_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (take_action_ocimem_a) begin
                    addr_d = jdo[AW+2:3];
                    if (jdo[36]) begin
                        drop_d = 1'b0;
`ifdef DEBUG_MEM_WR_VERIFY_EN
                        err_d  = 1'b0;
`endif
                    end
                    if (jdo[35]) begin
                        state_d = ST_RD_REQ;
                        incr_d  = 1'b0;
                    end
                end else if (take_action_ocimem_b) begin
                    wdata_d = jdo[34:3];
                    state_d = ST_WR_REQ;
                end else if (take_no_action_ocimem_a) begin
                    state_d = ST_RD_REQ;
                    incr_d  = 1'b1;
                end
            end
            ST_RD_REQ: begin
                if (!mem.mem_waitrequest) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                state_d = ST_RD_WAIT;
            end
            ST_WR_REQ: begin
                if (!mem.mem_waitrequest) begin
`ifdef DEBUG_MEM_WR_VERIFY_EN
                    // Address stays put so the verify read hits the written word
                    state_d = ST_VFY_REQ;
`else
                    addr_d  = addr_q + AW'(1);
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef DEBUG_MEM_WR_VERIFY_EN
            ST_VFY_REQ: begin
                if (!mem.mem_waitrequest) begin
                    state_d = ST_VFY_WAIT;
                end
            end
            ST_VFY_WAIT: begin
                state_d = ST_VFY_WAIT;
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Read completion overrides the accept-cycle move into a wait state
        if (rd_done) begin
            mon_dreg_d = mem.mem_rdata;
            state_d    = ST_IDLE;
            if (incr_q || is_vfy) begin
                addr_d = addr_q + AW'(1);
            end
`ifdef DEBUG_MEM_WR_VERIFY_EN
            if (is_vfy && (mem.mem_rdata != wdata_q)) begin
                err_d = 1'b1;
            end
`endif
        end

        if ((state_q != ST_IDLE) && any_strobe) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            mon_dreg_q <= '0;
            wdata_q    <= '0;
            drop_q     <= 1'b0;
            incr_q     <= 1'b0;
`ifdef DEBUG_MEM_WR_VERIFY_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            mon_dreg_q <= mon_dreg_d;
            wdata_q    <= wdata_d;
            drop_q     <= drop_d;
            incr_q     <= incr_d;
`ifdef DEBUG_MEM_WR_VERIFY_EN
            err_q      <= err_d;
`endif
        end
    end

    // Requests are decoded from registered state only, so address and data
    // cannot move while a request is being held off by waitrequest.
    assign mem.mem_addr  = addr_q;
    assign mem.mem_rd    = in_req;
    assign mem.mem_wr    = (state_q == ST_WR_REQ);
    assign mem.mem_wdata = wdata_q;

    assign MonDReg  = mon_dreg_q;
    assign mon_busy = (state_q != ST_IDLE);
    assign mon_drop = drop_q;
`ifdef DEBUG_MEM_WR_VERIFY_EN
    assign mon_err  = err_q;
`else
    assign mon_err  = 1'b0;
`endif

endmodule

// File: tb/tb_nis_cpu_uart_cpu_cpu_debug_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_nis_cpu_uart_cpu_cpu_debug_mem_ctrl
//
// Purpose:
//   Directed scenarios followed by randomized command streams for the debug
//   memory controller. The bench plays the memory slave itself and keeps a
//   small command-level model: current word address, last read word, sticky
//   flags. Honours DEBUG_MEM_WR_VERIFY_EN for the write read-back behaviour.
// ----------------------------------------------------------------------------
module tb_nis_cpu_uart_cpu_cpu_debug_mem_ctrl;

    localparam int AW = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [37:0] jdo = '0;
    logic        ta_a = 1'b0;
    logic        tna_a = 1'b0;
    logic        ta_b = 1'b0;
    logic [31:0] mon_dreg;
    logic        mon_busy;
    logic        mon_drop;
    logic        mon_err;

    nis_cpu_uart_cpu_cpu_debug_mem_ctrl_if #(.AW(AW)) mem_bus ();

    nis_cpu_uart_cpu_cpu_debug_mem_ctrl #(.AW(AW), .DW(32)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta_a),
        .take_no_action_ocimem_a (tna_a),
        .take_action_ocimem_b    (ta_b),
        .mem                     (mem_bus),
        .MonDReg                 (mon_dreg),
        .mon_busy                (mon_busy),
        .mon_drop                (mon_drop),
        .mon_err                 (mon_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Command-level model: what the host should see after each command
    logic [31:0] m_addr;
    logic [31:0] m_mon;
    logic [31:0] m_wdata;
    logic        m_drop;
    logic        m_err;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_busy"},  32'(mon_busy), 32'd0);
        checkOutput({tag, "_rd"},    32'(mem_bus.mem_rd), 32'd0);
        checkOutput({tag, "_wr"},    32'(mem_bus.mem_wr), 32'd0);
        checkOutput({tag, "_addr"},  32'(mem_bus.mem_addr), m_addr);
        checkOutput({tag, "_mon"},   mon_dreg, m_mon);
        checkOutput({tag, "_drop"},  32'(mon_drop), 32'(m_drop));
        checkOutput({tag, "_err"},   32'(mon_err), 32'(m_err));
    endtask

    task automatic modelReset();
        m_addr  = 32'd0;
        m_mon   = 32'd0;
        m_wdata = 32'd0;
        m_drop  = 1'b0;
        m_err   = 1'b0;
    endtask

    function automatic logic [31:0] nextAddr(input logic [31:0] a);
        return (a + 32'd1) % 32'd1024;
    endfunction

    // One-cycle strobe pulse with jdo held for that cycle
    task automatic applyStimulus(input bit a, input bit na, input bit b, input logic [37:0] j);
        ta_a  = a;
        tna_a = na;
        ta_b  = b;
        jdo   = j;
        @(negedge clk);
        ta_a  = 1'b0;
        tna_a = 1'b0;
        ta_b  = 1'b0;
    endtask

    // Slave side of one read: waitrequest stall, accept, then data after lat
    // cycles (same=1 returns data on the accept cycle). A stray strobe
    // (1=action_a, 2=no_action_a, 3=action_b) is raised on the completion cycle.
    task automatic serveRd(input int waits, input bit same, input int lat,
                           input logic [31:0] data, input int stray);
        for (int i = 0; i < waits; i++) begin
            mem_bus.mem_waitrequest = 1'b1;
            checkOutput("rd_held", 32'(mem_bus.mem_rd), 32'd1);
            checkOutput("rd_nowr", 32'(mem_bus.mem_wr), 32'd0);
            checkOutput("rd_addr", 32'(mem_bus.mem_addr), m_addr);
            @(negedge clk);
        end
        mem_bus.mem_waitrequest = 1'b0;
        checkOutput("rd_accept", 32'(mem_bus.mem_rd), 32'd1);
        checkOutput("rd_accept_addr", 32'(mem_bus.mem_addr), m_addr);
        if (!same) begin
            @(negedge clk);
            for (int i = 1; i < lat; i++) begin
                checkOutput("rd_wait_busy", 32'(mon_busy), 32'd1);
                checkOutput("rd_wait_nord", 32'(mem_bus.mem_rd), 32'd0);
                @(negedge clk);
            end
        end
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = data;
        ta_a  = (stray == 1);
        tna_a = (stray == 2);
        ta_b  = (stray == 3);
        @(negedge clk);
        ta_a  = 1'b0;
        tna_a = 1'b0;
        ta_b  = 1'b0;
        mem_bus.mem_rvalid = 1'b0;
        mem_bus.mem_rdata  = $urandom();
    endtask

    task automatic doRead(input int waits, input bit same, input int lat,
                          input logic [31:0] data, input int stray);
        logic [37:0] j;
        j = 38'({$urandom(), $urandom()});
        applyStimulus(1'b0, 1'b1, 1'b0, j);
        serveRd(waits, same, lat, data, stray);
        m_mon  = data;
        m_addr = nextAddr(m_addr);
        if (stray != 0) m_drop = 1'b1;
        checkIdle("read");
    endtask

    task automatic doLoad(input logic [9:0] addr, input bit prime, input bit clr,
                          input bit with_b, input bit with_na);
        logic [37:0] j;
        logic [31:0] data;
        j = 38'({$urandom(), $urandom()});
        j[12:3] = addr;
        j[35]   = prime;
        j[36]   = clr;
        applyStimulus(1'b1, with_na, with_b, j);
        m_addr = 32'(addr);
        if (clr) begin
            m_drop = 1'b0;
            m_err  = 1'b0;
        end
        if (prime) begin
            data = $urandom();
            serveRd($urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(1, 3), data, 0);
            m_mon = data;
        end
        checkIdle("load");
    endtask

    task automatic doWrite(input logic [31:0] data, input int waits, input logic [31:0] rb);
        logic [37:0] j;
        j = 38'({$urandom(), $urandom()});
        j[34:3] = data;
        applyStimulus(1'b0, 1'b0, 1'b1, j);
        m_wdata = data;
        for (int i = 0; i < waits; i++) begin
            mem_bus.mem_waitrequest = 1'b1;
            checkOutput("wr_held", 32'(mem_bus.mem_wr), 32'd1);
            checkOutput("wr_nord", 32'(mem_bus.mem_rd), 32'd0);
            checkOutput("wr_addr", 32'(mem_bus.mem_addr), m_addr);
            checkOutput("wr_data", mem_bus.mem_wdata, m_wdata);
            @(negedge clk);
        end
        mem_bus.mem_waitrequest = 1'b0;
        checkOutput("wr_accept", 32'(mem_bus.mem_wr), 32'd1);
        checkOutput("wr_accept_data", mem_bus.mem_wdata, m_wdata);
        @(negedge clk);
`ifdef DEBUG_MEM_WR_VERIFY_EN
        serveRd($urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(1, 3), rb, 0);
        m_mon = rb;
        if (rb !== data) m_err = 1'b1;
`else
        if (rb === 32'hxxxx_xxxx) m_mon = m_mon;
`endif
        m_addr = nextAddr(m_addr);
        checkIdle("write");
    endtask

    initial begin
        logic [31:0] d;
        int          kind;
        int          stray;

        mem_bus.mem_waitrequest = 1'b0;
        mem_bus.mem_rvalid      = 1'b0;
        mem_bus.mem_rdata       = 32'd0;
        modelReset();

        // Power-on reset
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        checkIdle("reset");

        // Reset while waiting for read data; late rvalid must be ignored
        doLoad(10'h123, 1'b0, 1'b0, 1'b0, 1'b0);
        doRead(0, 1'b0, 1, 32'hA5A5_0001, 0);
        applyStimulus(1'b0, 1'b1, 1'b0, jdo);
        mem_bus.mem_waitrequest = 1'b0;
        @(negedge clk);
        checkOutput("pre_reset_busy", 32'(mon_busy), 32'd1);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        modelReset();
        checkOutput("mid_reset_busy", 32'(mon_busy), 32'd0);
        checkOutput("mid_reset_rd", 32'(mem_bus.mem_rd), 32'd0);
        checkOutput("mid_reset_mon", mon_dreg, 32'd0);
        reset_n = 1'b1;
        mem_bus.mem_rvalid = 1'b1;
        mem_bus.mem_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        mem_bus.mem_rvalid = 1'b0;
        checkIdle("late_rvalid");

        // Streaming reads across the address wrap
        doLoad(10'h3FE, 1'b0, 1'b0, 1'b0, 1'b0);
        doRead(0, 1'b0, 1, 32'h1111_AAAA, 0);
        doRead(2, 1'b0, 2, 32'h2222_BBBB, 0);
        doRead(1, 1'b1, 1, 32'h3333_CCCC, 0);
        checkOutput("wrap_addr", 32'(mem_bus.mem_addr), 32'h001);

        // Prime read: no increment afterwards
        doLoad(10'h040, 1'b1, 1'b0, 1'b0, 1'b0);

        // Write held off for four cycles
        doLoad(10'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        doWrite(32'hDEAD_BEEF, 4, 32'hDEAD_BEEF);
        checkOutput("write_addr6", 32'(mem_bus.mem_addr), 32'd6);

        // Simultaneous strobes: address load wins, then drop and clear
        doLoad(10'h2AA, 1'b0, 1'b0, 1'b1, 1'b1);
        doRead(1, 1'b0, 2, 32'h0BAD_F00D, 2);
        checkOutput("drop_set", 32'(mon_drop), 32'd1);
        doLoad(10'h2AA, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("drop_clear", 32'(mon_drop), 32'd0);

        // Write verify mismatch (mon_err stays low without the verify build)
        doLoad(10'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        doWrite(32'h1234_5678, 0, 32'h1234_5679);
        checkOutput("vfy_addr8", 32'(mem_bus.mem_addr), 32'd8);
`ifdef DEBUG_MEM_WR_VERIFY_EN
        checkOutput("vfy_err", 32'(mon_err), 32'd1);
        checkOutput("vfy_mon", mon_dreg, 32'h1234_5679);
`else
        checkOutput("vfy_err", 32'(mon_err), 32'd0);
`endif

        // Randomized command stream
        for (int n = 0; n < 60; n++) begin
            kind  = $urandom_range(0, 3);
            stray = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            d     = $urandom();
            case (kind)
                0: doLoad(10'($urandom()), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                1, 2: doRead($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(1, 3), d, stray);
                default: doWrite(d, $urandom_range(0, 3), ($urandom_range(0, 1) == 1) ? d : ~d);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
